// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard receiver:
//                receive FSM state encoding, frame geometry, scan-code type
//                and the frame integrity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Full frame on the wire: start, 8 data, parity, stop.
  localparam int PS2_FRAME_BITS = 11;

  // Bits captured after the start bit (data, parity, stop).
  localparam int PS2_SAMPLE_BITS = PS2_FRAME_BITS - 1;

  typedef logic [7:0] scan_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } ps2_state_t;

  // Captured bits are {stop, parity, data[7:0]}; a frame is good when the
  // data plus parity has an odd number of ones and the stop bit is high.
  function automatic logic frame_ok(input logic [PS2_SAMPLE_BITS-1:0] bits);
    return (^bits[PS2_SAMPLE_BITS-2:0]) & bits[PS2_SAMPLE_BITS-1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_fifo
//  Description : Scan-code FIFO with extra-MSB pointers. The head entry is
//                held in a register so it stays stable (and keeps its last
//                value) when the FIFO runs empty. A push while full is only
//                accepted when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] count;
  scan_code_t    mem [DEPTH];
  scan_code_t    head;
  logic          do_pop;
  logic          do_push;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign rd_ptr_nxt = rd_ptr + PW'(1);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a
  // push that coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = head;

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head register: follows the next entry on a pop, takes the incoming byte
  // when it becomes the new head, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (do_pop) begin
      if (count != PW'(1)) begin
        head <= mem[rd_ptr_nxt[AW-1:0]];
      end else if (do_push) begin
        head <= din;
      end
    end else if (empty && do_push) begin
      head <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_rx
//  Description : PS/2 keyboard receiver. Synchronizes the keyboard clock and
//                data pins, samples data on each ps2_clk falling edge, checks
//                parity and stop bit, and queues good scan codes in a FIFO
//                with a valid/ready read port. Stalled frames are aborted
//                after TIMEOUT_CYC clk cycles without a falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       overflow_o,
  output logic       frame_err_o
);

  localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_SAMPLE_BITS - 1);

  // Synchronizers and edge detector
  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic dat_meta;
  logic dat_sync;
  logic fall;

  // Receive FSM and datapath
  ps2_state_t                 state;
  ps2_state_t                 state_nxt;
  logic [3:0]                 bit_cnt;
  logic [PS2_SAMPLE_BITS-1:0] shreg;
  logic [TW-1:0]              tmo_cnt;
  logic                       tmo_hit;
  logic                       push;
  logic                       frame_bad;
  logic                       abort;

  // FIFO interface
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  // Two-flop synchronizers on both pins plus a third ps2_clk flop for edges.
  // Idle-high pins, so the chain resets to 1 and no edge is seen on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_data;
      dat_sync <= dat_meta;
    end
  end

  assign fall    = clk_prev && !clk_sync;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus push / discard decisions for the finished frame.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frame_bad = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !dat_sync) state_nxt = RECV;
      end
      RECV: begin
        if (fall) begin
          if (bit_cnt == LAST_BIT) state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (frame_ok(shreg)) push      = 1'b1;
        else                 frame_bad = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit capture, bit counter and inter-edge timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        RECV: begin
          if (fall) begin
            // LSB-first on the wire: shift in from the top so the data byte
            // ends up in shreg[7:0] after the stop bit.
            shreg   <= {dat_sync, shreg[PS2_SAMPLE_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

  assign valid_o = !fifo_empty;
  assign pop     = valid_o && ready_i;

  // Error pulse for discarded frames and sticky overflow for dropped bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      frame_err_o <= frame_bad || abort;
      if (push && fifo_full && !pop) overflow_o <= 1'b1;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg[7:0]),
    .pop   (pop),
    .dout  (data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard_rx
//  Description : Directed self-checking bench for ps2_keyboard_rx. The inter-
//                edge timeout is shortened to TMO so the whole run stays
//                compact; the 0x1C frame still runs at a 12.5 kHz PS/2 clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

  localparam int TMO  = 5000;
  localparam int FAST = 25;    // half period in clk cycles
  localparam int SLOW = 2000;  // 12.5 kHz PS/2 clock from 50 MHz

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready_i  = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       overflow_o;
  logic       frame_err_o;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;
  logic [7:0] popped [$];

  ps2_keyboard_rx #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .overflow_o  (overflow_o),
    .frame_err_o (frame_err_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the read port and error pulse mid-cycle, after inputs settle.
  always @(negedge clk) begin
    #1;
    if (valid_o && ready_i) popped.push_back(data_o);
    if (valid_o) valid_cnt++;
    if (frame_err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int idx);
    if (idx < popped.size()) return 32'(popped[idx]);
    return 32'hDEAD;
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int half);
    ps2_data = b;
    wait_neg(half);
    ps2_clk = 1'b0;
    wait_neg(half);
    ps2_clk = 1'b1;
  endtask

  // Drives a whole frame and returns right after the stop-bit falling edge.
  task automatic frame_fall(input logic [7:0] b, input logic par_flip,
                            input logic stop_v, input int half);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      wait_neg(half);
      ps2_clk = 1'b0;
      if (i < 10) begin
        wait_neg(half);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic clk_release(input int half);
    wait_neg(half);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_neg(half);
  endtask

  task automatic send(input logic [7:0] b, input int half);
    frame_fall(b, 1'b0, 1'b1, half);
    clk_release(half);
  endtask

  // Clk cycles from the stop-bit falling edge until valid_o is first seen.
  task automatic measure_lat(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_o && lat == 0) lat = i;
    end
  endtask

  initial begin
    int lat;
    int e0;
    int v0;
    int p0;
    int d;

    // Reset values while rst is held
    wait_neg(5);
    check("rst_data",  32'(data_o),      32'h00);
    check("rst_valid", 32'(valid_o),     32'h0);
    check("rst_ovf",   32'(overflow_o),  32'h0);
    check("rst_ferr",  32'(frame_err_o), 32'h0);
    rst = 1'b0;
    wait_neg(5);

    // 0x1C at 12.5 kHz with ready_i high
    ready_i = 1'b1;
    e0 = err_cnt; v0 = valid_cnt; p0 = popped.size();
    frame_fall(8'h1C, 1'b0, 1'b1, SLOW);
    measure_lat(lat);
    check("lat_1c", 32'(lat >= 1 && lat <= 4), 32'h1);
    clk_release(SLOW);
    wait_neg(20);
    check("valid_cycles_1c", 32'(valid_cnt - v0), 32'd1);
    check("pops_1c",  32'(popped.size() - p0), 32'd1);
    check("data_1c",  pop_at(p0), 32'h1C);
    check("ferr_1c",  32'(err_cnt - e0), 32'd0);
    check("hold_1c",  32'(data_o), 32'h1C);

    // 0xF0 with wrong parity, then 0x33 with a bad stop bit
    e0 = err_cnt; v0 = valid_cnt;
    frame_fall(8'hF0, 1'b1, 1'b1, FAST);
    clk_release(FAST);
    wait_neg(10);
    check("ferr_par",  32'(err_cnt - e0), 32'd1);
    check("valid_par", 32'(valid_cnt - v0), 32'd0);
    frame_fall(8'h33, 1'b0, 1'b0, FAST);
    clk_release(FAST);
    wait_neg(10);
    check("ferr_stop",  32'(err_cnt - e0), 32'd2);
    check("valid_stop", 32'(valid_cnt - v0), 32'd0);

    // 0x01..0x09 with ready_i low: ninth overflows
    ready_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      frame_fall(8'(k), 1'b0, 1'b1, FAST);
      if (k == 1) begin
        measure_lat(lat);
        check("lat_empty", 32'(lat >= 1 && lat <= 4), 32'h1);
      end
      clk_release(FAST);
      if (k == 8) check("ovf_at8", 32'(overflow_o), 32'h0);
    end
    check("ovf_at9",   32'(overflow_o), 32'h1);
    check("head_full", 32'(data_o), 32'h01);
    p0 = popped.size();
    ready_i = 1'b1;
    wait_neg(20);
    check("drain_cnt", 32'(popped.size() - p0), 32'd8);
    for (int k = 0; k < 8; k++) check("drain_order", pop_at(p0 + k), 32'(k + 1));
    check("drain_valid", 32'(valid_o), 32'h0);
    check("drain_hold",  32'(data_o), 32'h08);
    check("ovf_sticky",  32'(overflow_o), 32'h1);

    // Reset after bit 4 of a frame, then a clean 0x5A
    for (int i = 0; i < 5; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, FAST);
    rst = 1'b1;
    wait_neg(2);
    check("mid_rst_data",  32'(data_o),      32'h00);
    check("mid_rst_valid", 32'(valid_o),     32'h0);
    check("mid_rst_ovf",   32'(overflow_o),  32'h0);
    check("mid_rst_ferr",  32'(frame_err_o), 32'h0);
    rst = 1'b0;
    wait_neg(5);
    e0 = err_cnt; p0 = popped.size();
    send(8'h5A, FAST);
    wait_neg(10);
    check("data_5a", pop_at(p0), 32'h5A);
    check("ferr_5a", 32'(err_cnt - e0), 32'd0);
    check("hold_5a", 32'(data_o), 32'h5A);

    // Full FIFO, stop-bit push coincides with a pop
    ready_i = 1'b0;
    for (int k = 0; k < 8; k++) send(8'(8'h10 + k), FAST);
    check("full_valid", 32'(valid_o), 32'h1);
    p0 = popped.size();
    frame_fall(8'h18, 1'b0, 1'b1, FAST);
    repeat (3) @(posedge clk);
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    clk_release(FAST);
    check("coinc_ovf",  32'(overflow_o), 32'h0);
    check("coinc_pop",  32'(popped.size() - p0), 32'd1);
    check("coinc_head", 32'(data_o), 32'h11);
    ready_i = 1'b1;
    wait_neg(20);
    check("coinc_total", 32'(popped.size() - p0), 32'd9);
    check("coinc_last",  pop_at(p0 + 8), 32'h18);
    check("coinc_empty", 32'(valid_o), 32'h0);

    // Five falling edges, then clock held high past the timeout
    e0 = err_cnt; v0 = valid_cnt;
    for (int i = 0; i < 4; i++) ps2_bit(1'b0, FAST);
    ps2_data = 1'b0;
    wait_neg(FAST);
    ps2_clk = 1'b0;
    d = cyc;
    wait_neg(FAST);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_neg(TMO + 1000);
    check("tmo_pulses", 32'(err_cnt - e0), 32'd1);
    d = err_cyc - d;
    check("tmo_window", 32'(d >= TMO && d <= TMO + 6), 32'h1);
    check("tmo_valid",  32'(valid_cnt - v0), 32'd0);
    // A falling edge with data high must not start a frame
    ps2_bit(1'b1, FAST);
    wait_neg(10);
    p0 = popped.size();
    send(8'h2A, FAST);
    wait_neg(10);
    check("data_2a", pop_at(p0), 32'h2A);
    check("ferr_2a", 32'(err_cnt - e0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries; power of two, 2 to 64.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; the block's only clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  keyboard clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  keyboard data pin, asynchronous to clk.
REQ-007 SHALL have port data_o  output  8  scan code at the FIFO head.
REQ-008 SHALL have port valid_o  output  1  FIFO not empty; data_o is valid.
REQ-009 SHALL have port ready_i  input  1  consumer accepts data_o this cycle.
REQ-010 SHALL have port overflow_o  output  1  sticky; a good frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse when a frame is discarded for bad parity, bad stop bit or timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, then a third ps2_clk flop for edge detection; the sample is taken only on a synchronized ps2_clk 1->0 transition.
REQ-013 SHALL receive an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-014 SHALL use FSM states IDLE, RECV and DONE; IDLE->RECV on a falling edge with data=0; IDLE stays IDLE on a falling edge with data=1.
REQ-015 SHALL count bits 1..10 in RECV with a 4-bit counter; RECV->DONE on the 10th sampled bit (the stop bit); DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL check in DONE that XOR(data, parity)=1 and stop=1; on pass, push data; on fail, pulse frame_err_o and discard.
REQ-017 SHALL reload the timeout counter on every falling edge while in RECV; at TIMEOUT_CYC it SHALL go RECV->IDLE, pulse frame_err_o and discard.
REQ-018 SHALL drive valid_o high no later than 4 clk cycles after the stop-bit falling edge at the pin, when the FIFO was previously empty.
REQ-019 SHALL pop the FIFO on a cycle with valid_o=1 and ready_i=1; data_o SHALL show the next entry in the following cycle, with no bubble.
REQ-020 SHALL let data_o hold its last value while valid_o=0; ready_i has no effect when the FIFO is empty.
REQ-021 SHALL, on a push with the FIFO full and no simultaneous pop, drop the byte, keep FIFO contents unchanged and set overflow_o.
REQ-022 SHALL, on a push with the FIFO full and a simultaneous pop, accept the byte; the count is unchanged and overflow_o is not set.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO holding one entry, pop the head and write the new byte; valid_o stays 1.
REQ-024 SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits; empty when pointers are equal; full when the MSBs differ and the rest are equal; pointers wrap naturally.

Reset
REQ-025 SHALL, on rst asserted, asynchronously set FSM=IDLE, bit counter=0, timeout counter=0, pointers=0, valid_o=0, data_o=0x00, overflow_o=0, frame_err_o=0 and synchronizer flops=1.
REQ-026 SHALL abort any partial frame on reset mid-frame, with no push; reception restarts at the next start bit after release.
REQ-027 SHALL clear overflow_o only by rst.

Structure
REQ-028 SHALL place in shared package ps2_pkg: the FSM state enum, PS2_FRAME_BITS=11 and the scan-code type (8-bit).
REQ-029 SHALL implement the FIFO as sub-module ps2_fifo (parameter DEPTH, push/pop/full/empty, registered storage); the FSM and synchronizers stay in ps2_keyboard_rx.

Verification
REQ-030 SHALL cover: frame 0x1C with good parity at a 12.5 kHz PS/2 clock and ready_i=1 -> valid_o for exactly 1 cycle, data_o=0x1C, frame_err_o=0.
REQ-031 SHALL cover: frame 0xF0 with a wrong parity bit -> frame_err_o pulses once, valid_o stays 0.
REQ-032 SHALL cover: 9 good frames 0x01..0x09 with ready_i=0 and depth 8 -> overflow_o=1; draining then returns 0x01..0x08 in order, and valid_o=0 afterwards.
REQ-033 SHALL cover: 5 falling edges, then the clock held high for 60000 cycles -> frame_err_o pulses at 50000; the next frame 0x2A is received correctly.
REQ-034 SHALL cover: FIFO full, and the stop-bit push coincides with a pop -> no overflow, count stays 8, the new byte is last out.
REQ-035 SHALL cover: rst asserted after bit 4 of a frame -> all outputs at reset values; after release, frame 0x5A yields data_o=0x5A.
